// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the execute-stage ALU issue controller: opselect codes,
// supported MIPS R-type funct codes and the controller FSM states.
package alu_issue_ctrl_pkg;

    // ALU opselect codes
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MULT = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SLL1 = 4'b0100;
    localparam logic [3:0] OP_SRL1 = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_NONE = 4'b1111;

    // MIPS R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_op_decode.sv
// Purpose: combinational MIPS funct -> ALU opselect / shift / illegal decode.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller samples the outputs only on its own handshake.
module alu_issue_ctrl_op_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] opselect,
    output logic       is_shift,
    output logic       illegal
);

    always_comb begin
        opselect = OP_NONE;
        is_shift = 1'b0;
        illegal  = 1'b0;
        case (funct)
            FN_ADD:  opselect = OP_ADD;
            FN_SUB:  opselect = OP_SUB;
            FN_MULT: opselect = OP_MULT;
            FN_DIV:  opselect = OP_DIV;
            FN_SLT:  opselect = OP_SLT;
            FN_AND:  opselect = OP_AND;
            FN_OR:   opselect = OP_OR;
            FN_NOR:  opselect = OP_NOR;
            FN_XOR:  opselect = OP_XOR;
            FN_SLL: begin
                opselect = OP_SLL1;
                is_shift = 1'b1;
            end
            FN_SRL: begin
                opselect = OP_SRL1;
                is_shift = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Purpose: issues one decoded R-type op to an external ALU, iterating shift-by-one for sll/srl.
// Latency: accept edge to out_valid = 2 cycles (non-shift), shamt+1 (shift), 1 (shift by 0).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         in_funct,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic [3:0]         alu_opselect,
    output logic [DATA_W-1:0]  alu_x,
    output logic [DATA_W-1:0]  alu_y,
    input  logic [DATA_W-1:0]  alu_res,
    input  logic               alu_v,
    input  logic               alu_c_out,
    input  logic               alu_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_res,
    output logic               out_v,
    output logic               out_c,
    output logic               out_zero,
    output logic               out_illegal
);

    state_t              state;
    logic [3:0]          op_q;
    logic                illegal_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   acc_q;
    logic [SHAMT_W-1:0]  cnt_q;

    logic [3:0]          dec_op;
    logic                dec_shift;
    logic                dec_illegal;

    alu_issue_ctrl_op_decode u_decode (
        .funct    (in_funct),
        .opselect (dec_op),
        .is_shift (dec_shift),
        .illegal  (dec_illegal)
    );

    assign in_ready = (state == ST_IDLE);

    // The ALU sees a neutral op whenever nothing is being computed.
    always_comb begin
        alu_opselect = OP_NONE;
        alu_x        = '0;
        alu_y        = '0;
        case (state)
            ST_EXEC: begin
                alu_opselect = op_q;
                alu_x        = a_q;
                alu_y        = b_q;
            end
            ST_SHIFT: begin
                alu_opselect = op_q;
                alu_x        = acc_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_q        <= OP_NONE;
            illegal_q   <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid   <= 1'b0;
            out_res     <= '0;
            out_v       <= 1'b0;
            out_c       <= 1'b0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q      <= dec_op;
                        illegal_q <= dec_illegal;
                        a_q       <= in_a;
                        b_q       <= in_b;
                        if (dec_shift && (in_shamt != '0)) begin
                            acc_q <= in_a;
                            cnt_q <= in_shamt;
                            state <= ST_SHIFT;
                        end else if (dec_shift) begin
                            // Shift by zero is a pass-through; the ALU is never used.
                            out_res     <= in_a;
                            out_zero    <= (in_a == '0);
                            out_v       <= 1'b0;
                            out_c       <= 1'b0;
                            out_illegal <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    out_res     <= alu_res;
                    out_v       <= alu_v;
                    out_c       <= alu_c_out;
                    out_zero    <= alu_zero;
                    out_illegal <= illegal_q;
                    out_valid   <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_SHIFT: begin
                    if (cnt_q == SHAMT_W'(1)) begin
                        out_res     <= alu_res;
                        out_zero    <= alu_zero;
                        out_v       <= 1'b0;
                        out_c       <= 1'b0;
                        out_illegal <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        acc_q <= alu_res;
                        cnt_q <= cnt_q - SHAMT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
